// File: rtl/vend_pkg.sv
// Shared constants for the vending sequencer: coin values/codes, price table, state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vend_pkg;

  // Coin face values in cents
  localparam int unsigned COIN_5  = 5;
  localparam int unsigned COIN_10 = 10;
  localparam int unsigned COIN_25 = 25;

  // Codes presented on chg_coin
  localparam logic [1:0] CC_5  = 2'd0;
  localparam logic [1:0] CC_10 = 2'd1;
  localparam logic [1:0] CC_25 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } vend_state_t;

  // Fixed price table, indexed by product number
  function automatic logic [7:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    price_of = 8'd25;
      2'd1:    price_of = 8'd50;
      2'd2:    price_of = 8'd75;
      default: price_of = 8'd100;
    endcase
  endfunction

endpackage

// File: rtl/vend_sequencer_if.sv
// Bundles the coin/select inputs, dispenser handshakes and display outputs of the sequencer.
// Latency: n/a (wiring only); slave = sequencer, master = the surrounding machine.
// Backpressure: vend_req/chg_req held until their acks; VEND_REFUND_EN adds the cancel pulse.
interface vend_sequencer_if #(
  parameter int CREDIT_W = 8
);
  logic [2:0]          coin;
  logic [3:0]          select;
  logic                vend_ack;
  logic                chg_ack;
`ifdef VEND_REFUND_EN
  logic                cancel;
`endif
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] price;
  logic [3:0]          product;
  logic                vend_req;
  logic                chg_req;
  logic [1:0]          chg_coin;
  logic                coin_reject;
  logic                short_funds;
  logic                busy;

`ifdef VEND_REFUND_EN
  modport master (
    output coin, select, vend_ack, chg_ack, cancel,
    input  credit, price, product, vend_req, chg_req, chg_coin, coin_reject, short_funds, busy
  );
  modport slave (
    input  coin, select, vend_ack, chg_ack, cancel,
    output credit, price, product, vend_req, chg_req, chg_coin, coin_reject, short_funds, busy
  );
`else
  modport master (
    output coin, select, vend_ack, chg_ack,
    input  credit, price, product, vend_req, chg_req, chg_coin, coin_reject, short_funds, busy
  );
  modport slave (
    input  coin, select, vend_ack, chg_ack,
    output credit, price, product, vend_req, chg_req, chg_coin, coin_reject, short_funds, busy
  );
`endif

endinterface

// File: rtl/vend_change_sel.sv
// Picks the largest change coin not exceeding the given credit (25, then 10, then 5).
// Latency: combinational.
// Backpressure: none; value is 0 when credit is below the smallest coin.
module vend_change_sel
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [1:0]          chg_coin,
  output logic [CREDIT_W-1:0] chg_val
);

  // Greedy coin choice, largest denomination first
  always_comb begin
    chg_coin = CC_5;
    chg_val  = '0;
    if (credit >= CREDIT_W'(COIN_25)) begin
      chg_coin = CC_25;
      chg_val  = CREDIT_W'(COIN_25);
    end else if (credit >= CREDIT_W'(COIN_10)) begin
      chg_coin = CC_10;
      chg_val  = CREDIT_W'(COIN_10);
    end else if (credit >= CREDIT_W'(COIN_5)) begin
      chg_coin = CC_5;
      chg_val  = CREDIT_W'(COIN_5);
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Vending control FSM: coin credit, priced selection, vend handshake, coin-by-coin change.
// Latency: all outputs registered, 1 cycle after the causing input; busy decoded from state.
// Backpressure: vend_req/chg_req held until ack; coins rejected while busy. VEND_REFUND_EN adds cancel.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 200
) (
  input  logic             clk,
  input  logic             reset,
  vend_sequencer_if.slave  bus
);

  vend_state_t         state;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] price_q;
  logic [3:0]          product_q;
  logic                vend_req_q;
  logic                chg_req_q;
  logic [1:0]          chg_coin_q;
  logic [CREDIT_W-1:0] chg_val_q;
  logic                coin_reject_q;
  logic                short_funds_q;

  logic                open_st;
  logic                coin_one;
  logic                sel_one;
  logic                coin_ok;
  logic                cancel_hit;
  logic [CREDIT_W-1:0] coin_amt;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W-1:0] credit_post;
  logic [CREDIT_W-1:0] sel_price;
  logic [CREDIT_W-1:0] remain;
  logic [1:0]          base_coin;
  logic [CREDIT_W-1:0] base_val;

  assign open_st  = (state == ST_IDLE) || (state == ST_CREDIT);
  assign coin_one = $onehot(bus.coin);
  assign sel_one  = $onehot(bus.select);

`ifdef VEND_REFUND_EN
  assign cancel_hit = bus.cancel;
`else
  assign cancel_hit = 1'b0;
`endif

  // Face value of a single inserted coin (0 for none or several bits)
  always_comb begin
    coin_amt = '0;
    case (bus.coin)
      3'b001:  coin_amt = CREDIT_W'(COIN_5);
      3'b010:  coin_amt = CREDIT_W'(COIN_10);
      3'b100:  coin_amt = CREDIT_W'(COIN_25);
      default: coin_amt = '0;
    endcase
  end

  // One extra bit so the ceiling compare cannot wrap
  assign coin_sum    = {1'b0, credit_q} + {1'b0, coin_amt};
  assign coin_ok     = open_st && coin_one && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign credit_post = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_q;

  // Price of the selected product (only meaningful for a one-hot select)
  always_comb begin
    sel_price = '0;
    case (bus.select)
      4'b0001: sel_price = CREDIT_W'(price_of(2'd0));
      4'b0010: sel_price = CREDIT_W'(price_of(2'd1));
      4'b0100: sel_price = CREDIT_W'(price_of(2'd2));
      4'b1000: sel_price = CREDIT_W'(price_of(2'd3));
      default: sel_price = '0;
    endcase
  end

  // Credit left after this cycle's settlement; drives the next change coin choice
  always_comb begin
    case (state)
      ST_CREDIT: remain = credit_post;
      ST_VEND:   remain = credit_q - price_q;
      ST_CHANGE: remain = credit_q - chg_val_q;
      default:   remain = credit_q;
    endcase
  end

  vend_change_sel #(.CREDIT_W(CREDIT_W)) u_change_sel (
    .credit   (remain),
    .chg_coin (base_coin),
    .chg_val  (base_val)
  );

  // Main FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      credit_q      <= '0;
      price_q       <= '0;
      product_q     <= '0;
      vend_req_q    <= 1'b0;
      chg_req_q     <= 1'b0;
      chg_coin_q    <= '0;
      chg_val_q     <= '0;
      coin_reject_q <= 1'b0;
      short_funds_q <= 1'b0;
    end else begin
      coin_reject_q <= (bus.coin != 3'b000) && !coin_ok;
      short_funds_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (coin_ok) begin
            credit_q <= credit_post;
            state    <= ST_CREDIT;
          end
        end
        ST_CREDIT: begin
          credit_q <= credit_post;
          if (cancel_hit) begin
            chg_req_q  <= 1'b1;
            chg_coin_q <= base_coin;
            chg_val_q  <= base_val;
            state      <= ST_CHANGE;
          end else if (sel_one) begin
            price_q <= sel_price;
            if (credit_post >= sel_price) begin
              product_q  <= bus.select;
              vend_req_q <= 1'b1;
              state      <= ST_VEND;
            end else begin
              short_funds_q <= 1'b1;
            end
          end
        end
        ST_VEND: begin
          if (bus.vend_ack) begin
            credit_q   <= remain;
            product_q  <= '0;
            vend_req_q <= 1'b0;
            if (remain != '0) begin
              chg_req_q  <= 1'b1;
              chg_coin_q <= base_coin;
              chg_val_q  <= base_val;
              state      <= ST_CHANGE;
            end else begin
              price_q <= '0;
              state   <= ST_IDLE;
            end
          end
        end
        ST_CHANGE: begin
          if (bus.chg_ack) begin
            credit_q <= remain;
            if (remain == '0) begin
              chg_req_q <= 1'b0;
              price_q   <= '0;
              state     <= ST_IDLE;
            end else begin
              chg_coin_q <= base_coin;
              chg_val_q  <= base_val;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.credit      = credit_q;
  assign bus.price       = price_q;
  assign bus.product     = product_q;
  assign bus.vend_req    = vend_req_q;
  assign bus.chg_req     = chg_req_q;
  assign bus.chg_coin    = chg_coin_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.short_funds = short_funds_q;
  assign bus.busy        = (state == ST_VEND) || (state == ST_CHANGE);

endmodule
